cv32e41p_div_arbiter: RTL and testbench

Two-requester controller that shares the single serial divider between the core ALU (requester 0) and the coprocessor port (requester 1). It arbitrates round-robin, pre-normalizes operand B (shift count, zero and sign flags), drives the divider's load/finish handshake, buffers the result and returns it to the owning requester. It also supports flushing requester 0's in-flight operation and an optional divide-by-zero bypass.

---
 rtl/cv32e41p_div_arbiter.sv | 106 ++++++++++
 tb/tb_cv32e41p_div_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41p_div_arbiter.sv
// cv32e41p_div_arbiter: round-robin sharing of one serial divider between the ALU (0) and the coprocessor port (1).
// Optional macro CV32E41P_DIV_ZERO_BYPASS_EN answers divide-by-zero without using the divider.
module cv32e41p_div_arbiter #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RI,
    input  logic [1:0]                    ReqVld_SI,
    output logic [1:0]                    ReqRdy_SO,
    input  logic [1:0][C_WIDTH-1:0]       ReqOpA_DI,
    input  logic [1:0][C_WIDTH-1:0]       ReqOpB_DI,
    input  logic [1:0][1:0]               ReqOpCode_SI,
    input  logic                          Flush_SI,
    output logic [1:0]                    RspVld_SO,
    input  logic [1:0]                    RspRdy_SI,
    output logic [C_WIDTH-1:0]            RspRes_DO,
    output logic [C_WIDTH-1:0]            DivOpA_DO,
    output logic [C_WIDTH-1:0]            DivOpB_DO,
    output logic [C_LOG_WIDTH-1:0]        DivOpBShift_DO,
    output logic                          DivOpBIsZero_SO,
    output logic                          DivOpBSign_SO,
    output logic [1:0]                    DivOpCode_SO,
    output logic                          DivInVld_SO,
    output logic                          DivOutRdy_SO,
    input  logic                          DivOutVld_SI,
    input  logic [C_WIDTH-1:0]            DivRes_DI
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;

    logic [1:0]             state;
    logic                   owner, drop, first, last;
    logic [C_WIDTH-1:0]     buffer;
    logic                   v0, v1, gnt, issue, sign, zero, bypass, drop_now;
    logic [C_WIDTH-1:0]     a, b;
    logic [1:0]             op;
    logic [C_LOG_WIDTH-1:0] shamt;

    function automatic logic [C_LOG_WIDTH-1:0] clz(input logic [C_WIDTH-1:0] x);
        clz = C_LOG_WIDTH'(C_WIDTH);
        for (int i = 0; i < C_WIDTH; i++)
            if (x[i]) clz = C_LOG_WIDTH'(C_WIDTH - 1 - i);
    endfunction

`ifdef CV32E41P_DIV_ZERO_BYPASS_EN
    assign bypass = zero;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        v0              = ReqVld_SI[0] & ~Flush_SI;
        v1              = ReqVld_SI[1];
        gnt             = (v0 & v1) ? ~last : v1;
        issue           = (state == IDLE) & ~Rst_RI & (v0 | v1);
        a               = ReqOpA_DI[gnt];
        b               = ReqOpB_DI[gnt];
        op              = ReqOpCode_SI[gnt];
        sign            = op[0] & b[C_WIDTH-1];
        zero            = (b == '0);
        // negative divisors keep one sign bit so the shifted value stays negative
        shamt           = sign ? clz(~b) - C_LOG_WIDTH'(1) : clz(b);
        ReqRdy_SO       = issue ? 2'b01 << gnt : 2'b00;
        DivInVld_SO     = issue & ~bypass;
        DivOpA_DO       = issue ? a : '0;
        DivOpB_DO       = issue ? b << shamt : '0;
        DivOpBShift_DO  = issue ? shamt : '0;
        DivOpBIsZero_SO = issue & zero;
        DivOpBSign_SO   = issue & sign;
        DivOpCode_SO    = issue ? op : 2'b00;
        DivOutRdy_SO    = (state == BUSY) & ~first & DivOutVld_SI;
        RspVld_SO       = (state == RESP) ? 2'b01 << owner : 2'b00;
        drop_now        = drop | (Flush_SI & ~owner);
    end

    assign RspRes_DO = buffer;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state  <= IDLE;
            owner  <= 1'b0;
            drop   <= 1'b0;
            first  <= 1'b0;
            last   <= 1'b1;
            buffer <= '0;
        end else if (state == IDLE) begin
            if (issue) begin
                last  <= gnt;
                owner <= gnt;
                drop  <= 1'b0;
                first <= 1'b1;
                state <= bypass ? RESP : BUSY;
                if (bypass) buffer <= op[1] ? a : '1;
            end
        end else if (state == BUSY) begin
            first <= 1'b0;
            if (Flush_SI & ~owner) drop <= 1'b1;
            if (DivOutRdy_SO) begin
                state <= drop_now ? IDLE : RESP;
                if (!drop_now) buffer <= DivRes_DI;
            end
        end else if (RspRdy_SI[owner] | (Flush_SI & ~owner)) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_cv32e41p_div_arbiter.sv
// tb_cv32e41p_div_arbiter: scoreboard bench for the divider arbiter with a cycle-accurate serial divider stub.
module tb_cv32e41p_div_arbiter;
    localparam int W  = 32;
    localparam int LW = 6;
`ifdef CV32E41P_DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 35;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          vld0 = 1'b0, vld1 = 1'b0, flush = 1'b0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]    op0 = 2'd0, op1 = 2'd0;
    logic [1:0]    rsp_rdy = 2'b11;

    logic [1:0]          req_vld, req_rdy, rsp_vld, div_op;
    logic [1:0][W-1:0]   req_a, req_b;
    logic [1:0][1:0]     req_op;
    logic [W-1:0]        rsp_res, div_a, div_b, div_res;
    logic [LW-1:0]       div_shift;
    logic                div_zero, div_sign, div_in_vld, div_out_rdy, div_out_vld;

    assign req_vld = {vld1, vld0};
    assign req_a   = {a1, a0};
    assign req_b   = {b1, b0};
    assign req_op  = {op1, op0};

    cv32e41p_div_arbiter #(.C_WIDTH(W), .C_LOG_WIDTH(LW)) dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .ReqVld_SI(req_vld), .ReqRdy_SO(req_rdy),
        .ReqOpA_DI(req_a), .ReqOpB_DI(req_b), .ReqOpCode_SI(req_op),
        .Flush_SI(flush),
        .RspVld_SO(rsp_vld), .RspRdy_SI(rsp_rdy), .RspRes_DO(rsp_res),
        .DivOpA_DO(div_a), .DivOpB_DO(div_b), .DivOpBShift_DO(div_shift),
        .DivOpBIsZero_SO(div_zero), .DivOpBSign_SO(div_sign), .DivOpCode_SO(div_op),
        .DivInVld_SO(div_in_vld), .DivOutRdy_SO(div_out_rdy),
        .DivOutVld_SI(div_out_vld), .DivRes_DI(div_res)
    );

    // Serial divider stub: DIVIDE for shift+1 cycles, then FINISH until consumed.
    function automatic logic [W-1:0] div_ref(logic [W-1:0] a, logic [W-1:0] bs, logic [LW-1:0] s,
                                             logic sg, logic [1:0] op);
        logic [W-1:0] b, q, r;
        b = sg ? W'($signed(bs) >>> s) : bs >> s;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (op[0]) begin
            if (a == 32'h8000_0000 && b == '1) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    logic [1:0] dst;
    int         dcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dst     <= 2'd0;
            dcnt    <= 0;
            div_res <= '0;
        end else if (dst == 2'd0) begin
            if (div_in_vld) begin
                dst     <= 2'd1;
                dcnt    <= int'(div_shift);
                div_res <= div_ref(div_a, div_b, div_shift, div_sign, div_op);
            end
        end else if (dst == 2'd1) begin
            if (dcnt == 0) dst <= 2'd2;
            else dcnt <= dcnt - 1;
        end else if (div_out_rdy) begin
            dst <= 2'd0;
        end
    end
    assign div_out_vld = (dst != 2'd1);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           id;
        logic [W-1:0] res;
        int           lat;
        int           acc;
    } exp_t;
    exp_t sbq[$];
    int   gq[$];
    int   n_chk = 0, n_fail = 0, n_rsp = 0, n_outrdy = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic [W-1:0] exp, input int lat, input bit push);
        int t = 0;
        @(negedge clk);
        if (id == 0) begin a0 = a; b0 = b; op0 = op; vld0 = 1'b1; end
        else begin a1 = a; b1 = b; op1 = op; vld1 = 1'b1; end
        #1;
        while (!req_rdy[id] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            chk("accept_timeout", 64'(t), 0);
        end else begin
            chk("grant_onehot", req_rdy, 2'b01 << id);
            if (div_in_vld) begin
                chk("div_zero", div_zero, b == '0);
                chk("div_sign", div_sign, op[0] & b[W-1]);
            end
            gq.push_back(id);
            if (push) sbq.push_back('{id, exp, lat, cyc});
        end
        @(posedge clk);
        #1;
        if (id == 0) vld0 = 1'b0;
        else vld1 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(sbq.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_outs_zero(input string nm);
        chk(nm, {req_rdy, rsp_vld, div_in_vld, div_out_rdy, div_zero, div_sign, div_op, div_shift}, 0);
        chk({nm, "_res"}, {rsp_res, div_a}, 0);
        chk({nm, "_divb"}, div_b, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (div_out_rdy) n_outrdy++;
                if (|(rsp_vld & rsp_rdy)) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_rsp", rsp_vld, 0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("rsp_owner", rsp_vld, 2'b01 << e.id);
                        chk("rsp_res", rsp_res, e.res);
                        if (e.lat >= 0) chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                    n_rsp++;
                end
            end
        join_none

        // requester valid during reset must not leak through
        a0 = 32'd55; b0 = 32'd3; vld0 = 1'b1;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset_outs");
        vld0 = 1'b0;
        rst = 1'b0;

        // both requesters contend from reset: 0 wins the first tie, then alternate
        fork
            begin
                issue(0, 32'd50, 32'd5, 2'd0, 32'd10, 32, 1'b1);
                issue(0, 32'd50, 32'd7, 2'd2, 32'd1, 32, 1'b1);
            end
            begin
                issue(1, -32'sd20, 32'd3, 2'd1, 32'hFFFF_FFFA, 33, 1'b1);
                issue(1, -32'sd20, 32'd3, 2'd3, 32'hFFFF_FFFE, 33, 1'b1);
            end
        join
        drain();
        chk("grant_order", (gq.size() == 4) ? gq[0] * 8 + gq[1] * 4 + gq[2] * 2 + gq[3] : -1, 5);
        gq.delete();

        issue(0, 32'd100, 32'd7, 2'd0, 32'd14, 32, 1'b1);
        drain();
        issue(1, -32'sd7, 32'd2, 2'd3, 32'hFFFF_FFFF, 33, 1'b1);
        drain();
        issue(0, 32'd100, -32'sd7, 2'd1, 32'hFFFF_FFF2, 31, 1'b1);
        drain();
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 32'h8000_0000, 34, 1'b1);
        drain();
        issue(0, 32'd10, 32'd0, 2'd1, 32'hFFFF_FFFF, ZLAT, 1'b1);
        drain();
        issue(1, 32'd123, 32'd0, 2'd2, 32'd123, ZLAT, 1'b1);
        drain();

        // flush of requester 0 in flight: result dropped, divider still drained once
        begin
            int o0, r0;
            o0 = n_outrdy;
            r0 = n_rsp;
            issue(0, 32'd100, 32'd7, 2'd0, 32'd0, -1, 1'b0);
            repeat (3) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            repeat (40) @(negedge clk);
            chk("flush_outrdy", 64'(n_outrdy - o0), 1);
            chk("flush_norsp", 64'(n_rsp - r0), 0);
            chk("flush_div_idle", dst, 0);
        end
        // flush does not touch an operation owned by requester 1
        issue(1, 32'd100, 32'd7, 2'd0, 32'd14, 32, 1'b1);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drain();

        // reset while BUSY, then a fresh request
        issue(0, 32'd1000, 32'd3, 2'd0, 32'd0, -1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs_zero("busy_reset_outs");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(0, 32'd9, 32'd4, 2'd2, 32'd1, 32, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
